// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit datapath: default word width and the
// register-bank clear FSM state encoding.
package datapath_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// Bulk-clear sequencer for reg_bank: walks a pointer over every entry once per
// request and reports progress through clr_busy / clr_done.
module reg_bank_clr_fsm
  import datapath_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_r, state_nx_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nx_s;
  logic              busy_r, busy_nx_s;
  logic              done_r, done_nx_s;

  // State, pointer and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ptr_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Next-state logic; clr_req is only looked at in IDLE, so requests during a
  // sequence are ignored and a held request restarts after completion.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    busy_nx_s  = busy_r;
    done_nx_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (clr_req) begin
          state_nx_s = S_CLEAR;
          ptr_nx_s   = '0;
          busy_nx_s  = 1'b1;
        end else begin
          state_nx_s = S_IDLE;
          busy_nx_s  = 1'b0;
        end
      end
      S_CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_nx_s = S_IDLE;
          ptr_nx_s   = '0;
          busy_nx_s  = 1'b0;
          done_nx_s  = 1'b1;
        end else begin
          ptr_nx_s  = ptr_r + ADDR_W'(1);
          busy_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        ptr_nx_s   = '0;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  assign clr_busy = busy_r;
  assign clr_done = done_r;
  assign clr_en   = (state_r == S_CLEAR);
  assign clr_addr = ptr_r;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register store: DEPTH x WIDTH entries, one write port,
// two registered write-first read ports and a sequential bulk clear.
module reg_bank
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_acc_s;
  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [WIDTH-1:0]  rd_nx_s [2];
  logic [WIDTH-1:0]  rd_q_r [2];

  reg_bank_clr_fsm #(.DEPTH(DEPTH)) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_en   (clr_en_s),
    .clr_addr (clr_addr_s)
  );

  // Writes are only accepted while idle and in range
  assign wr_acc_s     = wr_en & ~clr_en_s & in_range(wr_addr);
  assign rd_addr_s[0] = rd_addr_a;
  assign rd_addr_s[1] = rd_addr_b;

  // Storage array; the clear engine has priority (writes are blocked then anyway)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clr_en_s) begin
      mem_r[clr_addr_s] <= '0;
    end else if (wr_acc_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read muxes with clear and write bypass so a same-edge update is visible
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_nx_s[p] = '0;
      if (clr_en_s && (clr_addr_s == rd_addr_s[p])) begin
        rd_nx_s[p] = '0;
      end else if (wr_acc_s && (wr_addr == rd_addr_s[p])) begin
        rd_nx_s[p] = wr_data;
      end else if (in_range(rd_addr_s[p])) begin
        rd_nx_s[p] = mem_r[rd_addr_s[p]];
      end else begin
        rd_nx_s[p] = '0;
      end
    end
  end

  // Read data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q_r[0] <= '0;
      rd_q_r[1] <= '0;
    end else begin
      rd_q_r[0] <= rd_nx_s[0];
      rd_q_r[1] <= rd_nx_s[1];
    end
  end

  assign rd_data_a = rd_q_r[0];
  assign rd_data_b = rd_q_r[1];

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (8-deep main instance plus a
// 6-deep instance for out-of-range addressing).
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic        clr_req;
  logic [15:0] rd_data_a, rd_data_b;
  logic        clr_busy, clr_done;
  logic [15:0] rd6_a, rd6_b;
  logic        busy6, done6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd6_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd6_b),
    .clr_req(clr_req), .clr_busy(busy6), .clr_done(done6)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; clr_req = 1'b0;
    #3;
    chk("rst_rd_a", rd_data_a, 16'h0000);
    chk("rst_rd_b", rd_data_b, 16'h0000);
    chk("rst_busy", {15'd0, clr_busy}, 16'h0000);
    chk("rst_done", {15'd0, clr_done}, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // all entries read zero after reset
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      tick();
      chk("init_a", rd_data_a, 16'h0000);
      chk("init_b", rd_data_b, 16'h0000);
    end
    chk("init_busy", {15'd0, clr_busy}, 16'h0000);

    // write then read on both ports
    wr(3'd3, 16'h1234);
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    tick();
    chk("wr_rd_a", rd_data_a, 16'h1234);
    chk("wr_rd_b", rd_data_b, 16'h1234);

    // write-first bypass on port A only
    rd_addr_a = 3'd5; rd_addr_b = 3'd2;
    wr(3'd5, 16'hBEEF);
    chk("byp_a", rd_data_a, 16'hBEEF);
    chk("byp_b", rd_data_b, 16'h0000);

    // fill and run a clear sequence with reads during it
    for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h1111 * k));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_start_busy", {15'd0, clr_busy}, 16'h0001);
    chk("clr_start_done", {15'd0, clr_done}, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      rd_addr_a = 3'd6; rd_addr_b = 3'(c - 1);
      tick();
      chk("clr_rd6", rd_data_a, (c < 7) ? 16'h6666 : 16'h0000);
      chk("clr_byp", rd_data_b, 16'h0000);
      chk("clr_busy", {15'd0, clr_busy}, (c < 8) ? 16'h0001 : 16'h0000);
      chk("clr_done", {15'd0, clr_done}, (c == 8) ? 16'h0001 : 16'h0000);
    end
    tick();
    chk("clr_done_pulse", {15'd0, clr_done}, 16'h0000);
    chk("clr_rd6_after", rd_data_a, 16'h0000);

    // simultaneous write+clear, writes and requests during busy, held request
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222; clr_req = 1'b1; rd_addr_a = 3'd2;
    tick();
    wr_en = 1'b0;
    chk("wrclr_byp", rd_data_a, 16'h2222);
    chk("wrclr_busy", {15'd0, clr_busy}, 16'h0001);
    n = 0;
    while (!clr_done && n < 20) begin
      wr_en = 1'b0;
      if (n == 1) begin wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hAAAA; end
      if (n == 2) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA; rd_addr_a = 3'd0; end
      tick();
      n++;
      if (n == 3) chk("busy_wr_nobyp", rd_data_a, 16'h0000);
    end
    wr_en = 1'b0;
    chk("seq_len", 16'(n), 16'd8);
    tick();
    chk("restart_busy", {15'd0, clr_busy}, 16'h0001);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 20) begin tick(); n++; end
    chk("restart_len", 16'(n), 16'd8);
    rd_addr_a = 3'd7; rd_addr_b = 3'd2;
    tick();
    chk("drop_e7", rd_data_a, 16'h0000);
    chk("erase_e2", rd_data_b, 16'h0000);
    rd_addr_a = 3'd0;
    tick();
    chk("drop_e0", rd_data_a, 16'h0000);

    // reset in the middle of a clear
    wr(3'd4, 16'h4444);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0; rd_addr_a = 3'd4;
    tick(); tick(); tick();
    chk("pre_rst_rd", rd_data_a, 16'h4444);
    chk("pre_rst_busy", {15'd0, clr_busy}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd_data_a, 16'h0000);
    chk("mid_rst_busy", {15'd0, clr_busy}, 16'h0000);
    chk("mid_rst_done", {15'd0, clr_done}, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_busy", {15'd0, clr_busy}, 16'h0000);
    chk("post_rst_done", {15'd0, clr_done}, 16'h0000);
    chk("post_rst_e4", rd_data_a, 16'h0000);
    wr(3'd1, 16'h5A5A);
    rd_addr_a = 3'd1;
    tick();
    chk("post_rst_wr", rd_data_a, 16'h5A5A);

    // out-of-range addresses on the 6-deep instance
    rd_addr_a = 3'd6; rd_addr_b = 3'd5;
    wr(3'd6, 16'h6666);
    chk("oor_nobyp", rd6_a, 16'h0000);
    chk("inr_byp8", rd_data_a, 16'h6666);
    tick();
    chk("oor_rd", rd6_a, 16'h0000);
    wr(3'd5, 16'h5555);
    chk("d6_byp5", rd6_b, 16'h5555);
    tick();
    chk("d6_rd5", rd6_b, 16'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised multi-entry successor to the single 16-bit load register. Provides DEPTH registers of WIDTH bits each.
- Ports: one synchronous write port, two registered read ports with write-through bypass, and a sequential bulk-clear engine with a busy/done handshake.
- Sits between the control unit and the ALU as the general-purpose register store of the 16-bit datapath.

Parameters:
- WIDTH, 16, bits per register entry.
- DEPTH, 8, number of entries; must be ≥ 2.
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write enable, sampled on the rising edge of clk.
- wr_addr  input  ADDR_W  write entry index.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_data_a  output  WIDTH  read port A data, registered.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_b  output  WIDTH  read port B data, registered.
- clr_req  input  1  request to clear all entries; single-cycle pulse or level.
- clr_busy  output  1  high while the clear sequence runs.
- clr_done  output  1  one-cycle pulse when the clear sequence completes.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries are 0.
  - rd_data_a and rd_data_b are 0.
  - clr_busy and clr_done are 0.
  - FSM is in IDLE and the clear pointer is 0.
  - Release is synchronous to clk via the usual flop behaviour; nothing happens in the first edge beyond normal operation.
- Write: if wr_en=1 at a rising edge and FSM=IDLE, then entry[wr_addr] <= wr_data.
- Read: rd_data_x <= entry[rd_addr_x] at every rising edge, giving 1-cycle latency. There is no read enable.
- Bypass: if an accepted write has the same address as a read in the same cycle, rd_data_x gets wr_data (write-first). Both ports bypass independently.
- Out-of-range addresses (DEPTH not a power of 2, addr ≥ DEPTH):
  - Writes are dropped.
  - Reads return 0.
- FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1. The clear pointer is set to 0 and clr_busy goes to 1 on the next edge.
  - In CLEAR, each edge sets entry[ptr] <= 0 and ptr <= ptr+1, so the sequence takes exactly DEPTH cycles.
  - When ptr = DEPTH-1 is cleared: FSM -> IDLE, clr_busy -> 0, clr_done -> 1 for one cycle.
- Writes while clr_busy=1 are dropped silently, with no error flag. The caller must poll clr_busy.
- clr_req while clr_busy=1 is ignored; the sequence does not restart.
- clr_req held high through completion starts a new sequence on the edge after clr_done. This is level-sensitive and intended.
- Reads during CLEAR are allowed:
  - An entry already cleared returns 0; an entry not yet cleared returns its old value.
  - Reading the entry being cleared on that same edge returns 0 (clear bypass, same rule as the write bypass).
- Simultaneous clr_req and wr_en in IDLE: the write is accepted on that edge, then clearing starts. The written value is erased by the sequence.
- Reset mid-clear: all state returns to reset values immediately and clr_done does not pulse.
- No arithmetic except the pointer increment (ADDR_W bits). The pointer never wraps because the sequence terminates at DEPTH-1.

Decomposition:
- Shared package datapath_pkg holds:
  - the default WIDTH (16);
  - the clear-FSM state enum (S_IDLE, S_CLEAR), so control-unit monitors can decode it.
- One natural sub-module: reg_bank_clr_fsm, which owns the state, the pointer, clr_busy and clr_done, and outputs the clear-enable and clear-address to the storage array.
- Storage and read muxes stay in reg_bank.

Test Plan:
- Reset then read all addresses -> rd_data_a/b = 0x0000 one cycle after each address is presented; clr_busy = 0.
- Write 0x1234 to entry 3, next cycle read A=3, B=3 -> both ports show 0x1234 one cycle later.
- Same cycle wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr_a=5 -> rd_data_a = 0xBEEF after that edge (bypass); rd_data_b at addr 2 is unaffected.
- Fill entries 0..7 with 0x1111*k; pulse clr_req -> clr_busy high for exactly 8 cycles, clr_done a single pulse on the 8th. During the sequence:
  - a read of entry 6 at cycle 3 returns 0x6666;
  - a read of entry 6 after completion returns 0x0000.
- During clr_busy, issue write 0xAAAA to entry 7 and a second clr_req -> the write is dropped (entry 7 reads 0x0000 after done), and the sequence length stays 8.
- Assert rst_n low at clear cycle 4 -> outputs go to 0 immediately and the FSM returns to IDLE with no clr_done. After release, write and readback of 0x5A5A at entry 1 work normally.
